// File: rtl/ip_codma_rd_machine_if.sv
// rtl/ip_codma_rd_machine_if.sv - system read bus between the CODMA read engine and the fabric
interface ip_codma_rd_machine_if;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic [7:0]  bus_size_o;
    logic        bus_gnt_i;
    logic        bus_valid_i;
    logic [63:0] bus_rdata_i;
    logic        bus_error_i;

    modport master (
        output bus_req_o, bus_addr_o, bus_size_o,
        input  bus_gnt_i, bus_valid_i, bus_rdata_i, bus_error_i
    );

    modport slave (
        input  bus_req_o, bus_addr_o, bus_size_o,
        output bus_gnt_i, bus_valid_i, bus_rdata_i, bus_error_i
    );
endinterface

// File: rtl/ip_codma_rd_machine.sv
// rtl/ip_codma_rd_machine.sv - CODMA bus-read engine packing 64-bit beats into data_reg
// Optional watchdog enabled by defining CODMA_RD_TIMEOUT_EN.
module ip_codma_rd_machine #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        need_read_i,
    input  logic [31:0] reg_addr,
    input  logic [7:0]  reg_size,
    input  logic        stop_i,
    output logic        need_read_o,
    output logic [31:0] data_reg [8],
    output logic [2:0]  rd_state_o,
    output logic [2:0]  rd_state_next_o,
    output logic        rd_state_error,
    ip_codma_rd_machine_if.master bus
);
    typedef enum logic [2:0] {
        RD_IDLE    = 3'd0,
        RD_ASK     = 3'd1,
        RD_GRANTED = 3'd2,
        RD_DRAIN   = 3'd3,
        RD_ERROR   = 3'd4
    } rd_state_t;

    rd_state_t  state;
    rd_state_t  state_next;
    logic [2:0] beat_cnt;
    logic [1:0] beat_idx;
    logic       timeout;
    logic       active;
    logic       legal;
    logic       last_beat;
    logic       consume;
    logic       capture;

    function automatic logic [2:0] beats_of(input logic [7:0] size);
        case (size)
            8'd3:    return 3'd1;
            8'd8:    return 3'd2;
            8'd9:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    assign active    = (state == RD_ASK) || (state == RD_GRANTED) || (state == RD_DRAIN);
    assign legal     = (beats_of(reg_size) != 3'd0) && (reg_addr[2:0] == 3'd0);
    assign last_beat = bus.bus_valid_i && (beat_cnt == 3'd1);
    // A beat is consumed in GRANTED/DRAIN unless an error or watchdog preempts it; stop only suppresses the write.
    assign consume   = ((state == RD_GRANTED) || (state == RD_DRAIN)) && bus.bus_valid_i
                       && !bus.bus_error_i && !timeout;
    assign capture   = consume && (state == RD_GRANTED) && !stop_i;

`ifdef CODMA_RD_TIMEOUT_EN
    logic [15:0] wdog;

    assign timeout = active && (wdog == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wdog <= '0;
        end else if ((state_next != state) || bus.bus_valid_i || !active) begin
            wdog <= '0;
        end else begin
            wdog <= wdog + 16'd1;
        end
    end
`else
    assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_next = state;
        case (state)
            RD_IDLE: begin
                if (need_read_i) state_next = legal ? RD_ASK : RD_ERROR;
            end
            RD_ASK: begin
                if (bus.bus_error_i || timeout) state_next = RD_ERROR;
                else if (stop_i)                state_next = RD_IDLE;
                else if (bus.bus_gnt_i)         state_next = RD_GRANTED;
            end
            RD_GRANTED: begin
                if (bus.bus_error_i || timeout) state_next = RD_ERROR;
                else if (last_beat)             state_next = RD_IDLE;
                else if (stop_i)                state_next = RD_DRAIN;
            end
            RD_DRAIN: begin
                if (bus.bus_error_i || timeout) state_next = RD_ERROR;
                else if (last_beat)             state_next = RD_IDLE;
            end
            default: state_next = RD_IDLE;
        endcase
    end

    assign rd_state_o      = state;
    assign rd_state_next_o = state_next;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state          <= RD_IDLE;
            need_read_o    <= 1'b0;
            bus.bus_req_o  <= 1'b0;
            bus.bus_addr_o <= '0;
            bus.bus_size_o <= '0;
            rd_state_error <= 1'b0;
            beat_cnt       <= '0;
            beat_idx       <= '0;
            for (int i = 0; i < 8; i++) data_reg[i] <= '0;
        end else begin
            state          <= state_next;
            need_read_o    <= (state_next == RD_ASK) || (state_next == RD_GRANTED)
                              || (state_next == RD_DRAIN);
            bus.bus_req_o  <= (state_next == RD_ASK);
            rd_state_error <= (state_next == RD_ERROR);
            if ((state == RD_IDLE) && need_read_i) begin
                bus.bus_addr_o <= reg_addr;
                bus.bus_size_o <= reg_size;
                beat_cnt       <= beats_of(reg_size);
                beat_idx       <= '0;
                for (int i = 0; i < 8; i++) data_reg[i] <= '0;
            end
            if (consume) begin
                beat_cnt <= beat_cnt - 3'd1;
                beat_idx <= beat_idx + 2'd1;
            end
            if (capture) begin
                data_reg[{beat_idx, 1'b0}] <= bus.bus_rdata_i[31:0];
                data_reg[{beat_idx, 1'b1}] <= bus.bus_rdata_i[63:32];
            end
        end
    end
endmodule
